// File: rtl/fp_mul_result_stage.sv
// +--------------------------------------------------------------------------+
// | fp_mul_result_stage                                                      |
// | Two-entry skid buffer behind the FP multiplier, plus sticky exception    |
// | flags and saturating exception/result event counters.                   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module fp_mul_result_stage #(
    parameter int EXPONENT_WIDTH = 8,
    parameter int MANTISSA_WIDTH = 23,
    parameter int COUNTER_WIDTH  = 16
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0]  in_result,
    input  logic [2:0]                              in_flags,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0]  out_result,
    output logic [2:0]                              out_flags,
    input  logic                                    clear_sticky,
    output logic [2:0]                              sticky_flags,
    output logic [COUNTER_WIDTH-1:0]                underflow_count,
    output logic [COUNTER_WIDTH-1:0]                overflow_count,
    output logic [COUNTER_WIDTH-1:0]                invalid_count,
    output logic [COUNTER_WIDTH-1:0]                result_count
);

    localparam int c_result_w = EXPONENT_WIDTH + MANTISSA_WIDTH + 1;
    localparam logic [COUNTER_WIDTH-1:0] c_cnt_max = '1;
    localparam logic [COUNTER_WIDTH-1:0] c_cnt_one = COUNTER_WIDTH'(1);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_in_ready;
    logic [c_result_w-1:0]   r_head_result;
    logic [c_result_w-1:0]   r_tail_result;
    logic [2:0]              r_head_flags;
    logic [2:0]              r_tail_flags;
    logic [2:0]              r_sticky;
    logic [COUNTER_WIDTH-1:0] r_result_cnt;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_load_head_in;
    logic                    w_load_head_tail;
    logic                    w_load_tail;

    assign w_push    = in_valid && r_in_ready;
    assign w_pop     = out_valid && out_ready;
    assign out_valid = (r_state != S_EMPTY);

    always_comb begin
        w_state_nxt      = r_state;
        w_load_head_in   = 1'b0;
        w_load_head_tail = 1'b0;
        w_load_tail      = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_push) begin
                    w_state_nxt    = S_ONE;
                    w_load_head_in = 1'b1;
                end
            end
            S_ONE: begin
                if (w_push && w_pop) begin
                    w_load_head_in = 1'b1;
                end else if (w_push) begin
                    w_state_nxt = S_TWO;
                    w_load_tail = 1'b1;
                end else if (w_pop) begin
                    w_state_nxt = S_EMPTY;
                end
            end
            S_TWO: begin
                // in_ready is low here, so only a pop can happen
                if (w_pop) begin
                    w_state_nxt      = S_ONE;
                    w_load_head_tail = 1'b1;
                end
            end
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_EMPTY;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != S_TWO);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head_result <= '0;
            r_head_flags  <= '0;
            r_tail_result <= '0;
            r_tail_flags  <= '0;
        end else begin
            if (w_load_head_in) begin
                r_head_result <= in_result;
                r_head_flags  <= in_flags;
            end else if (w_load_head_tail) begin
                r_head_result <= r_tail_result;
                r_head_flags  <= r_tail_flags;
            end
            if (w_load_tail) begin
                r_tail_result <= in_result;
                r_tail_flags  <= in_flags;
            end
        end
    end

    // A flag pushed in the same cycle as a clear survives the clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky <= '0;
        end else begin
            r_sticky <= (clear_sticky ? 3'b000 : r_sticky) | (w_push ? in_flags : 3'b000);
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_exc_cnt
        logic [COUNTER_WIDTH-1:0] r_cnt;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt <= '0;
            end else if (clear_sticky) begin
                r_cnt <= (w_push && in_flags[i]) ? c_cnt_one : '0;
            end else if (w_push && in_flags[i] && (r_cnt != c_cnt_max)) begin
                r_cnt <= r_cnt + c_cnt_one;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result_cnt <= '0;
        end else if (w_pop && (r_result_cnt != c_cnt_max)) begin
            r_result_cnt <= r_result_cnt + c_cnt_one;
        end
    end

    assign in_ready        = r_in_ready;
    assign out_result      = r_head_result;
    assign out_flags       = r_head_flags;
    assign sticky_flags    = r_sticky;
    assign underflow_count = g_exc_cnt[0].r_cnt;
    assign overflow_count  = g_exc_cnt[1].r_cnt;
    assign invalid_count   = g_exc_cnt[2].r_cnt;
    assign result_count    = r_result_cnt;

endmodule

`default_nettype wire
